// File: rtl/button_pkg.sv
// Shared types and timing constants for the button/switch input conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HELD   = 2'd3
  } btn_state_e;

  // 100 MHz board timing: 10 ms debounce, 500 ms first repeat, 100 ms repeat period
  localparam int unsigned BOARD_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned BOARD_REPEAT_DELAY    = 50_000_000;
  localparam int unsigned BOARD_REPEAT_PERIOD   = 10_000_000;

  localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;
  localparam int unsigned SIM_REPEAT_DELAY    = 20;
  localparam int unsigned SIM_REPEAT_PERIOD   = 8;

  // Counter width for a count of n cycles, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debounce filter.
module sync_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      // Accept the new level only after it has disagreed for DEBOUNCE_CYCLES samples
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the count button into step pulses and the direction switch into a level.
// BUTTON_AUTO_REPEAT_EN builds in auto-repeat while the button stays held.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = BOARD_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = BOARD_REPEAT_PERIOD
) (
  input  logic clk100m,
  input  logic rst,
  input  logic btn_raw,
  input  logic sw_dir_raw,
  output logic step,
  output logic dir,
  output logic held
);

  // Reload values below 1 would let step stay high on back-to-back cycles
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
    $error("button_conditioner: invalid timing parameters");
  end

  logic       btn_lvl;
  logic       held_prev_q;
  logic       step_q;
  logic       rise;
  logic       fall;
  btn_state_e state_q;

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk_i   (clk100m),
    .rst_i   (rst),
    .raw_i   (btn_raw),
    .level_o (btn_lvl)
  );

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
    .clk_i   (clk100m),
    .rst_i   (rst),
    .raw_i   (sw_dir_raw),
    .level_o (dir)
  );

  assign rise = btn_lvl & ~held_prev_q;
  assign fall = ~btn_lvl & held_prev_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q;

  always_ff @(posedge clk100m) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rpt_q       <= '0;
      step_q      <= 1'b0;
      held_prev_q <= 1'b0;
    end else begin
      held_prev_q <= btn_lvl;
      step_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            step_q  <= 1'b1;
            rpt_q   <= DELAY_LOAD;
            state_q <= ST_FIRST;
          end
        end
        // Release wins over a terminal count landing on the same cycle
        ST_FIRST, ST_REPEAT: begin
          if (fall) begin
            state_q <= ST_IDLE;
          end else if (rpt_q == '0) begin
            step_q  <= 1'b1;
            rpt_q   <= PERIOD_LOAD;
            state_q <= ST_REPEAT;
          end else begin
            rpt_q <= rpt_q - RPT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk100m) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= 1'b0;
      held_prev_q <= 1'b0;
    end else begin
      held_prev_q <= btn_lvl;
      step_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            step_q  <= 1'b1;
            state_q <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (fall) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
`endif

  assign step = step_q;
  assign held = btn_lvl;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized checks of button_conditioner against a cycle-level reference model.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int unsigned D  = SIM_DEBOUNCE_CYCLES;
  localparam int unsigned RD = SIM_REPEAT_DELAY;
  localparam int unsigned RP = SIM_REPEAT_PERIOD;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, btn_raw, sw_dir_raw;
  logic step, dir, held;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk100m    (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .sw_dir_raw (sw_dir_raw),
    .step       (step),
    .dir        (dir),
    .held       (held)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: sync pipe, window of the last D synced samples, and press/repeat schedule
  logic         m_s1_b = 0, m_s2_b = 0, m_f_b = 0, m_p_b = 0;
  logic         m_s1_d = 0, m_s2_d = 0, m_f_d = 0;
  logic [D-1:0] m_hist_b = '0, m_hist_d = '0;
  logic         m_step = 0;
  bit           m_active = 0;
  int           m_abs = 0, m_due = 0;

  // Scenario bookkeeping
  int cyc = 0;
  int steps_q[$];
  int held_rise, held_fall, dir_rise;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_steps(input string tag, input int exp_q[$]);
    int n;
    chk_int({tag, "_count"}, steps_q.size(), exp_q.size());
    n = (steps_q.size() < exp_q.size()) ? steps_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk_int({tag, "_cycle"}, steps_q[i], exp_q[i]);
  endtask

  task automatic model_edge();
    m_abs++;
    if (rst) begin
      {m_s1_b, m_s2_b, m_f_b, m_p_b, m_s1_d, m_s2_d, m_f_d} = '0;
      m_hist_b = '0;
      m_hist_d = '0;
      m_step   = 1'b0;
      m_active = 1'b0;
    end else begin
      m_step = 1'b0;
      if (m_f_b && !m_p_b) begin
        m_step   = 1'b1;
        m_active = 1'b1;
        m_due    = m_abs + int'(RD);
      end else if (m_active && !m_f_b) begin
        m_active = 1'b0;
      end else if (REP_EN && m_active && m_abs == m_due) begin
        m_step = 1'b1;
        m_due  = m_abs + int'(RP);
      end
      m_p_b    = m_f_b;
      m_hist_b = {m_hist_b[D-2:0], m_s2_b};
      if (m_hist_b == {D{~m_f_b}}) m_f_b = ~m_f_b;
      m_hist_d = {m_hist_d[D-2:0], m_s2_d};
      if (m_hist_d == {D{~m_f_d}}) m_f_d = ~m_f_d;
      m_s2_b = m_s1_b;
      m_s1_b = btn_raw;
      m_s2_d = m_s1_d;
      m_s1_d = sw_dir_raw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    cyc++;
    chk("step", step, m_step);
    chk("held", held, m_f_b);
    chk("dir", dir, m_f_d);
    if (step === 1'b1) steps_q.push_back(cyc);
    if (held === 1'b1 && held_rise < 0) held_rise = cyc;
    if (held === 1'b0 && held_rise >= 0 && held_fall < 0) held_fall = cyc;
    if (dir === 1'b1 && dir_rise < 0) dir_rise = cyc;
  endtask

  task automatic begin_scn();
    cyc = 0;
    steps_q.delete();
    held_rise = -1;
    held_fall = -1;
    dir_rise  = -1;
  endtask

  int exp_q[$];

  initial begin
    rst = 1'b1;
    btn_raw = 1'b0;
    sw_dir_raw = 1'b0;
    begin_scn();
    repeat (3) tick();
    chk("reset_step", step, 1'b0);
    chk("reset_held", held, 1'b0);
    chk("reset_dir", dir, 1'b0);
    rst = 1'b0;
    repeat (10) tick();

    // Clean press, 10-cycle hold
    begin_scn();
    btn_raw = 1'b1;
    repeat (10) tick();
    btn_raw = 1'b0;
    repeat (20) tick();
    exp_q = '{7};
    chk_steps("clean_steps", exp_q);
    chk_int("clean_held_rise", held_rise, 6);
    chk_int("clean_held_fall", held_fall, 16);

    // Bounce: toggles every 2 cycles never settle long enough
    begin_scn();
    for (int k = 0; k < 20; k++) begin
      btn_raw = ((k / 2) % 2 == 0);
      tick();
    end
    btn_raw = 1'b0;
    repeat (20) tick();
    exp_q = {};
    chk_steps("bounce_steps", exp_q);
    chk_int("bounce_held_rise", held_rise, -1);

    // 60-cycle hold; release terminal count collides with the release edge
    begin_scn();
    btn_raw = 1'b1;
    repeat (60) tick();
    btn_raw = 1'b0;
    repeat (20) tick();
    if (REP_EN) exp_q = '{7, 27, 35, 43, 51, 59};
    else        exp_q = '{7};
    chk_steps("repeat_steps", exp_q);
    chk_int("repeat_held_fall", held_fall, 66);

    // Direction switch flips mid-repeat
    begin_scn();
    btn_raw = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 31) sw_dir_raw = 1'b1;
      tick();
    end
    btn_raw = 1'b0;
    repeat (20) tick();
    chk_steps("dir_steps", exp_q);
    chk_int("dir_rise", dir_rise, 36);
    sw_dir_raw = 1'b0;
    repeat (12) tick();
    chk("dir_fall", dir, 1'b0);

    // Reset for 3 cycles while held restarts the press sequence
    begin_scn();
    btn_raw = 1'b1;
    for (int k = 1; k <= 79; k++) begin
      rst = (k >= 41 && k <= 43);
      tick();
      if (k >= 41 && k <= 43) begin
        chk("rst_mid_step", step, 1'b0);
        chk("rst_mid_held", held, 1'b0);
      end
    end
    rst = 1'b0;
    btn_raw = 1'b0;
    repeat (20) tick();
    if (REP_EN) exp_q = '{7, 27, 35, 50, 70, 78};
    else        exp_q = '{7, 50};
    chk_steps("rst_steps", exp_q);

    // Random segments of glitches, holds, switch moves and occasional resets
    begin_scn();
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      len = (($urandom % 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 45));
      btn_raw = 1'($urandom);
      if (($urandom % 4) == 0) sw_dir_raw = ~sw_dir_raw;
      for (int k = 0; k < len; k++) begin
        rst = (($urandom % 200) == 0);
        tick();
      end
      rst = 1'b0;
    end
    btn_raw = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
